reg_file_p: RTL and testbench

Parametrised successor to the processor's 16×16 register file: a configurable-width, configurable-depth, two-read/one-write register file with register 0 hardwired to zero and a reset-driven clear sequencer. Sits in the decode stage. Read ports are combinational and feed the ALU operand muxes. The write port is driven from writeback. The clear sequencer zeroes storage one entry per cycle, so the array still maps to LUT/distributed RAM rather than flops with a global reset. An optional write-through bypass removes the writeback-to-decode hazard.

---
 rtl/reg_file_p_if.sv | 29 ++
 rtl/reg_file_p.sv | 113 +++++++++++
 tb/tb_reg_file_p.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/reg_file_p_if.sv
// reg_file_p_if: bus bundle for the reg_file_p register file.
//   master : writeback/decode side (drives Load/Caddr/C/Aaddr/Baddr, sees A/B/ready)
//   slave  : register file side
// Parameters WIDTH/DEPTH must match those of the attached reg_file_p.
interface reg_file_p_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              Load;
    logic [ADDR_W-1:0] Caddr;
    logic [WIDTH-1:0]  C;
    logic [ADDR_W-1:0] Aaddr;
    logic [ADDR_W-1:0] Baddr;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              ready;

    modport master (
        output Load, Caddr, C, Aaddr, Baddr,
        input  A, B, ready
    );

    modport slave (
        input  Load, Caddr, C, Aaddr, Baddr,
        output A, B, ready
    );
endinterface

// File: rtl/reg_file_p.sv
// reg_file_p: parametrised 2-read / 1-write register file, register 0 reads zero.
//
// A reset starts a clear sweep that zeroes one entry per cycle (entries 1..DEPTH-1),
// so the storage array carries no reset and can map to distributed RAM. While the
// sweep runs, writes are dropped and both read ports return zero.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, (re)starts the clear sweep
//   bus.Load     write enable, bus.Caddr write address, bus.C write data
//   bus.Aaddr    read address A -> bus.A (combinational)
//   bus.Baddr    read address B -> bus.B (combinational)
//   bus.ready    high once the sweep is complete and writes are accepted
//
// Optional feature: define REG_FILE_BYPASS_EN to forward the write data C onto
// A/B in the same cycle when the read address matches an accepted write.
module reg_file_p #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_p_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic              clr_we;
    logic              wr_en;

    // Entry 0 is never written; reads of address 0 are masked below.
    logic [WIDTH-1:0]  mem [DEPTH];

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= ONE;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        clr_we     = 1'b0;
        wr_en      = 1'b0;
        case (state)
            CLEAR: begin
                clr_we   = 1'b1;
                ptr_next = ptr + ONE;
                if (ptr == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                wr_en = bus.Load && (bus.Caddr != '0);
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Storage: no reset on the data, rst only blocks the write (rst beats Load).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[ptr] <= '0;
            end else if (wr_en) begin
                mem[bus.Caddr] <= bus.C;
            end
        end
    end

    assign bus.ready = (state == IDLE);

    // Read ports: zero during the sweep and for address 0, otherwise array (or bypass).
    always_comb begin
        bus.A = '0;
        bus.B = '0;
        if (state == IDLE) begin
            if (bus.Aaddr != '0) begin
                bus.A = mem[bus.Aaddr];
`ifdef REG_FILE_BYPASS_EN
                if (bus.Load && (bus.Caddr == bus.Aaddr)) begin
                    bus.A = bus.C;
                end
`endif
            end
            if (bus.Baddr != '0) begin
                bus.B = mem[bus.Baddr];
`ifdef REG_FILE_BYPASS_EN
                if (bus.Load && (bus.Caddr == bus.Baddr)) begin
                    bus.B = bus.C;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_reg_file_p.sv
// tb_reg_file_p: self-checking bench for reg_file_p (16x16 instance plus a 32x32
// instance). A behavioural model (value array, clear-in-progress flag and a count
// of clean edges since reset) predicts A, B and ready every cycle.
module tb_reg_file_p;
    localparam int W  = 16;
    localparam int D  = 16;
    localparam int W2 = 32;
    localparam int D2 = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    reg_file_p_if #(.WIDTH(W),  .DEPTH(D))  bus  ();
    reg_file_p_if #(.WIDTH(W2), .DEPTH(D2)) bus2 ();

    reg_file_p #(.WIDTH(W),  .DEPTH(D))  dut  (.clk(clk), .rst(rst),  .bus(bus));
    reg_file_p #(.WIDTH(W2), .DEPTH(D2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    int vectors     = 0;
    int miscompares = 0;

    // Reference model for the 16x16 instance
    logic [W-1:0] model [D];
    bit           in_clear = 1'b1;
    int           clean_edges = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_rd(input logic [3:0] a);
        if (in_clear || a == 4'd0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (bus.Load && bus.Caddr == a) return bus.C;
`endif
        return model[a];
    endfunction

    // Apply the effect of one clock edge with the current inputs.
    task automatic model_edge();
        if (rst) begin
            in_clear    = 1'b1;
            clean_edges = 0;
            for (int i = 0; i < D; i++) model[i] = '0;
        end else if (in_clear) begin
            clean_edges++;
            if (clean_edges == D - 1) in_clear = 1'b0;
        end else if (bus.Load && bus.Caddr != 4'd0) begin
            model[bus.Caddr] = bus.C;
        end
    endtask

    // One cycle: check outputs for the current inputs, clock, update model.
    task automatic cyc(input string tag);
        #1;
        check({tag, ".A"},     64'(bus.A),     64'(exp_rd(bus.Aaddr)));
        check({tag, ".B"},     64'(bus.B),     64'(exp_rd(bus.Baddr)));
        check({tag, ".ready"}, 64'(bus.ready), 64'(!in_clear));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        bus.Load = 1'b0; bus.Caddr = '0; bus.C = '0; bus.Aaddr = 4'd5; bus.Baddr = 4'd15;
        bus2.Load = 1'b0; bus2.Caddr = '0; bus2.C = '0; bus2.Aaddr = '0; bus2.Baddr = '0;

        // Reset sweep: one rst cycle then 15 clear edges
        rst = 1'b1;
        @(posedge clk); model_edge(); #1;
        check("rst.ready", 64'(bus.ready), 64'd0);
        check("rst.A", 64'(bus.A), 64'd0);
        check("rst.B", 64'(bus.B), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < D - 1; i++) cyc("sweep");
        check("sweep.ready_up", 64'(bus.ready), 64'd1);

        // Write/read register 3
        bus.Load = 1'b1; bus.Caddr = 4'd3; bus.C = 16'hBEEF; bus.Aaddr = 4'd2; bus.Baddr = 4'd4;
        cyc("wr3");
        bus.Load = 1'b0; bus.Aaddr = 4'd3; bus.Baddr = 4'd3;
        #1;
        check("wr3.A", 64'(bus.A), 64'hBEEF);
        check("wr3.B", 64'(bus.B), 64'hBEEF);
        cyc("rd3");
        bus.Aaddr = 4'd2; bus.Baddr = 4'd4;
        cyc("others");

        // Zero register: write to address 0 is dropped, reads stay 0
        bus.Load = 1'b1; bus.Caddr = 4'd0; bus.C = 16'hFFFF; bus.Aaddr = 4'd0; bus.Baddr = 4'd0;
        #1;
        check("zero.pre", 64'(bus.A), 64'd0);
        cyc("zero");
        bus.Load = 1'b0;
        #1;
        check("zero.post", 64'(bus.A), 64'd0);

        // Bypass behaviour on register 4
        bus.Load = 1'b1; bus.Caddr = 4'd4; bus.C = 16'h0001; bus.Aaddr = 4'd1;
        cyc("byp.init");
        bus.C = 16'h00AA; bus.Aaddr = 4'd4; bus.Baddr = 4'd4;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("byp.pre", 64'(bus.A), 64'h00AA);
`else
        check("byp.pre", 64'(bus.A), 64'h0001);
`endif
        cyc("byp");
        bus.Load = 1'b0;
        #1;
        check("byp.post", 64'(bus.A), 64'h00AA);
        check("byp.postB", 64'(bus.B), 64'h00AA);

        // Writes during clear are dropped; rst mid-sweep restarts it
        rst = 1'b1; bus.Load = 1'b1; bus.Caddr = 4'd7; bus.C = 16'h1234; bus.Aaddr = 4'd7;
        cyc("clr.rst");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cyc("clr.part");
        rst = 1'b1;
        cyc("clr.rst2");
        rst = 1'b0;
        for (int i = 0; i < D - 2; i++) cyc("clr.resweep");
        check("clr.not_yet", 64'(bus.ready), 64'd0);
        cyc("clr.last");    // Load=1 on the edge ready rises: dropped
        check("clr.ready", 64'(bus.ready), 64'd1);
        bus.Load = 1'b0;
        #1;
        check("clr.reg7", 64'(bus.A), 64'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 79) == 0);
            bus.Load  = $urandom_range(0, 1);
            bus.Aaddr = 4'($urandom);
            bus.Baddr = 4'($urandom);
            bus.Caddr = ($urandom_range(0, 3) == 0) ? bus.Aaddr : 4'($urandom);
            bus.C     = 16'($urandom);
            cyc("rand");
        end
        rst = 1'b0; bus.Load = 1'b0;
        for (int i = 0; i < D; i++) cyc("drain");

        // 32x32 instance: 31-cycle clear, then reg31 round trip
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        for (int i = 1; i <= D2 - 1; i++) begin
            @(posedge clk); #1;
            check("w32.ready", 64'(bus2.ready), (i == D2 - 1) ? 64'd1 : 64'd0);
        end
        bus2.Load = 1'b1; bus2.Caddr = 5'd31; bus2.C = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus2.Load = 1'b0; bus2.Aaddr = 5'd31; bus2.Baddr = 5'd31;
        #1;
        check("w32.A", 64'(bus2.A), 64'hDEADBEEF);
        check("w32.B", 64'(bus2.B), 64'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
